// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory arbiter.
package dmem_pkg;

    // Access size encoding carried on req_size; 2'b11 is reserved/illegal.
    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_t;

    localparam logic [1:0] SZ_ILL = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Accepted request as held through the access cycle.
    typedef struct packed {
        logic        id;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        err;
    } req_t;

    // Illegal size, misaligned half/word, or word index beyond the memory.
    function automatic logic access_err(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input int unsigned depth);
        logic bad_size;
        logic misalign;
        logic out_of_range;
        bad_size     = (size == SZ_ILL);
        misalign     = ((size == SZ_H) && addr[0]) ||
                       ((size == SZ_W) && (addr[1:0] != 2'b00));
        out_of_range = ({2'b00, addr[31:2]} >= depth);
        return bad_size || misalign || out_of_range;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/replicated data and load extraction.
// Purely combinational so it can be exercised on its own.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr,
    input  logic        i_uns,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_mem_rd,
    output logic [3:0]  o_be,
    output logic [31:0] o_wd_aligned,
    output logic [31:0] o_rdata_ext
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Store side: lanes enabled by size/offset, data replicated across lanes
    // so whichever lane is enabled already carries the right bits.
    always_comb begin
        o_be         = 4'b0000;
        o_wd_aligned = 32'h0;
        case (i_size)
            SZ_B: begin
                o_be         = 4'b0001 << i_addr;
                o_wd_aligned = {4{i_wdata[7:0]}};
            end
            SZ_H: begin
                o_be         = i_addr[1] ? 4'b1100 : 4'b0011;
                o_wd_aligned = {2{i_wdata[15:0]}};
            end
            SZ_W: begin
                o_be         = 4'b1111;
                o_wd_aligned = i_wdata;
            end
            default: begin
                o_be         = 4'b0000;
                o_wd_aligned = 32'h0;
            end
        endcase
    end

    // Load side: pick the addressed byte/half out of the word.
    always_comb begin
        w_byte = i_mem_rd[7:0];
        case (i_addr)
            2'd0:    w_byte = i_mem_rd[7:0];
            2'd1:    w_byte = i_mem_rd[15:8];
            2'd2:    w_byte = i_mem_rd[23:16];
            default: w_byte = i_mem_rd[31:24];
        endcase
        w_half = i_addr[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];
    end

    // Sign- or zero-extend the selected lane; words pass straight through.
    always_comb begin
        o_rdata_ext = 32'h0;
        case (i_size)
            SZ_B:    o_rdata_ext = i_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            SZ_H:    o_rdata_ext = i_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            SZ_W:    o_rdata_ext = i_mem_rd;
            default: o_rdata_ext = 32'h0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin front end for a single-port byte-enable data memory.
// Port 0 = core LSU, port 1 = debug/DMA loader. One transaction per 2 cycles:
// handshake (IDLE) -> memory access (ACCESS) -> response pulse.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter logic        RR_INIT = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [1:0]       i_req_valid,
    output logic [1:0]       o_req_ready,
    input  logic [1:0]       i_req_we,
    input  logic [1:0][1:0]  i_req_size,
    input  logic [1:0]       i_req_unsigned,
    input  logic [1:0][31:0] i_req_addr,
    input  logic [1:0][31:0] i_req_wdata,
    output logic [1:0]       o_rsp_valid,
    output logic             o_rsp_err,
    output logic [31:0]      o_rsp_rdata,
    output logic [3:0]       o_mem_we,
    output logic [31:0]      o_mem_a,
    output logic [31:0]      o_mem_wd,
    input  logic [31:0]      i_mem_rd
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_last_grant;
    req_t        r_req;
    req_t        w_req_nxt;
    logic [1:0]  r_rsp_valid;
    logic        r_rsp_err;
    logic [31:0] r_rsp_rdata;

    logic [1:0]  w_grant;
    logic        w_sel;
    logic        w_hs;
    logic [3:0]  w_be;
    logic [31:0] w_wd_aligned;
    logic [31:0] w_rdata_ext;

    // Round-robin pick: a lone requester wins; on contention the port that
    // did not win last time gets it.
    always_comb begin
        w_grant = 2'b00;
        case (i_req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last_grant ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
        endcase
    end

    assign w_sel = w_grant[1];

    // Snapshot of the winning port's request, error decided up front so the
    // access cycle only has to gate the write.
    always_comb begin
        w_req_nxt       = '0;
        w_req_nxt.id    = w_sel;
        w_req_nxt.we    = i_req_we[w_sel];
        w_req_nxt.size  = i_req_size[w_sel];
        w_req_nxt.uns   = i_req_unsigned[w_sel];
        w_req_nxt.addr  = i_req_addr[w_sel];
        w_req_nxt.wdata = i_req_wdata[w_sel];
        w_req_nxt.err   = access_err(i_req_size[w_sel], i_req_addr[w_sel], DEPTH);
    end

    dmem_lane_align u_align (
        .i_size       (r_req.size),
        .i_addr       (r_req.addr[1:0]),
        .i_uns        (r_req.uns),
        .i_wdata      (r_req.wdata),
        .i_mem_rd     (i_mem_rd),
        .o_be         (w_be),
        .o_wd_aligned (w_wd_aligned),
        .o_rdata_ext  (w_rdata_ext)
    );

    // Next state and memory-side outputs. Memory pins are decoded from the
    // state register only, so an async reset mid-access kills mem_we at once.
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 2'b00;
        o_mem_we    = 4'b0000;
        o_mem_a     = 32'h0;
        o_mem_wd    = 32'h0;
        w_hs        = 1'b0;
        case (r_state)
            IDLE: begin
                // grant already implies valid, so any grant bit is a transfer
                o_req_ready = w_grant;
                w_hs        = |w_grant;
                if (w_hs) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                o_mem_a     = r_req.addr;
                o_mem_wd    = w_wd_aligned;
                o_mem_we    = (r_req.err || !r_req.we) ? 4'b0000 : w_be;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, arbitration history and accepted request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= RR_INIT;
            r_req        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_last_grant <= w_sel;
                r_req        <= w_req_nxt;
            end
        end
    end

    // Response: one-cycle valid pulse to the owner; data/err hold until the
    // next response overwrites them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rsp_valid <= 2'b00;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
        end else begin
            r_rsp_valid <= 2'b00;
            if (r_state == ACCESS) begin
                r_rsp_valid <= r_req.id ? 2'b10 : 2'b01;
                r_rsp_err   <= r_req.err;
                r_rsp_rdata <= (r_req.err || r_req.we) ? 32'h0 : w_rdata_ext;
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_err   = r_rsp_err;
    assign o_rsp_rdata = r_rsp_rdata;

    // Requesters must keep valid and payload steady until accepted.
    for (genvar g = 0; g < 2; g++) begin : g_req_chk
        a_hold_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            (i_req_valid[g] && !o_req_ready[g]) |=> i_req_valid[g]);
        a_hold_payload: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            (i_req_valid[g] && !o_req_ready[g]) |=>
            $stable({i_req_we[g], i_req_size[g], i_req_unsigned[g],
                     i_req_addr[g], i_req_wdata[g]}));
    end

endmodule
